cordic_div_sched: RTL and testbench

//  Shares one cordic_div instance between N_REQ requesters, round-robin.
//  - Accepts a dividend/divisor pair from one requester.
//  - Sequences the divider's en/flag handshake.
//  - Returns the quotient to the requester that issued it.
//  - Sits between the node-level compute blocks and the single divider.

---
 rtl/cordic_div_pkg.sv | 22 ++
 rtl/cordic_div_sched_rr_pick.sv | 28 ++
 rtl/cordic_div_sched.sv | 96 +++++++++
 tb/tb_cordic_div_sched.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_div_pkg.sv
// Shared constants for the divider scheduler: datapath width, FSM state codes
// and the saturated quotients returned for a zero divisor.
package cordic_div_pkg;

    localparam int CDIV_W = 16;

    localparam logic [1:0] CDIV_IDLE   = 2'd0;
    localparam logic [1:0] CDIV_LAUNCH = 2'd1;
    localparam logic [1:0] CDIV_WAIT   = 2'd2;
    localparam logic [1:0] CDIV_RESP   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = CDIV_IDLE,
        ST_LAUNCH = CDIV_LAUNCH,
        ST_WAIT   = CDIV_WAIT,
        ST_RESP   = CDIV_RESP
    } cdiv_state_t;

    localparam logic [CDIV_W-1:0] CDIV_QMAX = 16'h7FFF;
    localparam logic [CDIV_W-1:0] CDIV_QMIN = 16'h8000;

endpackage

// File: rtl/cordic_div_sched_rr_pick.sv
// Round-robin picker: returns the first requester at or after ptr that has
// req_valid set, wrapping modulo N_REQ.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int PTR_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_valid,
    input  logic [PTR_W-1:0] ptr,
    output logic [PTR_W-1:0] grant,
    output logic             any_valid
);

    // Walk from the farthest candidate back to ptr so the nearest one wins.
    always_comb begin
        int idx;
        idx       = 0;
        grant     = '0;
        any_valid = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (req_valid[idx]) begin
                grant     = PTR_W'(idx);
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cordic_div_sched.sv
// Shares one cordic_div between N_REQ requesters, round-robin, one op in flight.
// Optional macro CDIV_ZERO_BYPASS_EN: a zero divisor is answered with a saturated
// quotient without launching the divider.
module cordic_div_sched
    import cordic_div_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int W     = CDIV_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [N_REQ*W-1:0] req_dividend,
    input  logic [N_REQ*W-1:0] req_divisor,
    output logic [N_REQ-1:0]   req_ack,
    output logic [N_REQ-1:0]   rsp_valid,
    output logic [W-1:0]       rsp_quotient,
    output logic               busy,
    output logic               div_en,
    output logic [W-1:0]       div_dividend,
    output logic [W-1:0]       div_divisor,
    input  logic [W-1:0]       div_quotient,
    input  logic               div_flag
);

    localparam int PTR_W = $clog2(N_REQ);

    cdiv_state_t      state_q, state_d;
    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] gnt_q;
    logic [PTR_W-1:0] grant;
    logic             any_valid;
    logic             take;
    logic             zero_div;
    logic [W-1:0]     sel_dividend;
    logic [W-1:0]     sel_divisor;

    rr_pick #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_pick (
        .req_valid (req_valid),
        .ptr       (ptr_q),
        .grant     (grant),
        .any_valid (any_valid)
    );

    assign sel_dividend = req_dividend[grant*W +: W];
    assign sel_divisor  = req_divisor[grant*W +: W];
    // Grants are only taken in IDLE, and never while reset is being applied.
    assign take         = (state_q == ST_IDLE) && any_valid && rst;

`ifdef CDIV_ZERO_BYPASS_EN
    assign zero_div = (sel_divisor == '0);
`else
    assign zero_div = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (take) state_d = zero_div ? ST_RESP : ST_LAUNCH;
            ST_LAUNCH: state_d = ST_WAIT;
            ST_WAIT:   if (div_flag) state_d = ST_RESP;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    assign req_ack   = take ? (N_REQ'(1) << grant) : '0;
    assign rsp_valid = (state_q == ST_RESP) ? (N_REQ'(1) << gnt_q) : '0;
    assign div_en    = (state_q == ST_LAUNCH);
    assign busy      = (state_q != ST_IDLE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            ptr_q        <= '0;
            gnt_q        <= '0;
            div_dividend <= '0;
            div_divisor  <= '0;
            rsp_quotient <= '0;
        end else begin
            state_q <= state_d;
            if (take) begin
                gnt_q        <= grant;
                div_dividend <= sel_dividend;
                div_divisor  <= sel_divisor;
`ifdef CDIV_ZERO_BYPASS_EN
                if (zero_div) rsp_quotient <= sel_dividend[W-1] ? CDIV_QMIN : CDIV_QMAX;
`endif
            end
            if (state_q == ST_WAIT && div_flag) rsp_quotient <= div_quotient;
            if (state_q == ST_RESP)
                ptr_q <= (gnt_q == PTR_W'(N_REQ - 1)) ? '0 : gnt_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_cordic_div_sched.sv
// Bench for cordic_div_sched: directed scenarios then random traffic, checked
// cycle by cycle against a transaction-level model of grants, latency and quotients.
module tb_cordic_div_sched;

    localparam int N = 4;
    localparam int W = 16;
`ifdef CDIV_ZERO_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_dividend;
    logic [N*W-1:0] req_divisor;
    logic [N-1:0]   req_ack;
    logic [N-1:0]   rsp_valid;
    logic [W-1:0]   rsp_quotient;
    logic           busy;
    logic           div_en;
    logic [W-1:0]   div_dividend;
    logic [W-1:0]   div_divisor;
    logic [W-1:0]   div_quotient;
    logic           div_flag;

    cordic_div_sched #(.N_REQ(N), .W(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_dividend (req_dividend),
        .req_divisor  (req_divisor),
        .req_ack      (req_ack),
        .rsp_valid    (rsp_valid),
        .rsp_quotient (rsp_quotient),
        .busy         (busy),
        .div_en       (div_en),
        .div_dividend (div_dividend),
        .div_divisor  (div_divisor),
        .div_quotient (div_quotient),
        .div_flag     (div_flag)
    );

    function automatic logic [W-1:0] ref_div(logic [W-1:0] a, logic [W-1:0] b);
        int sa;
        int ub;
        sa = int'($signed(a));
        ub = int'(b);
        if (ub == 0) return '0;
        return W'(sa / ub);
    endfunction

    // Divider stand-in: en sampled at cycle-1 edge, flag high in cycle 19.
    logic [4:0]   st_cnt;
    logic         st_flag;
    logic [W-1:0] st_q;
    logic         stray;
    always_ff @(posedge clk) begin
        if (!rst) begin
            st_cnt  <= '0;
            st_flag <= 1'b0;
            st_q    <= '0;
        end else begin
            st_flag <= 1'b0;
            if (div_en) begin
                st_cnt <= 5'd17;
                st_q   <= ref_div(div_dividend, div_divisor);
            end else if (st_cnt != 0) begin
                st_cnt  <= st_cnt - 1'b1;
                st_flag <= (st_cnt == 5'd1);
            end
        end
    end
    assign div_flag     = st_flag | stray;
    assign div_quotient = st_q;

    // ---------------- checking ----------------
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // ---------------- reference model + scoreboard ----------------
    logic [W-1:0] exp_q[$];
    bit           m_busy = 1'b0;
    int           m_t    = 0;
    int           m_g    = 0;
    int           m_ptr  = 0;
    bit           m_zero = 1'b0;
    logic [W-1:0] m_dd, m_dv;
    logic [W-1:0] m_rspq = '0;

    // Stimulus shadow state, applied just after each rising edge.
    logic [N-1:0] rv = '0;
    logic [W-1:0] dd[N];
    logic [W-1:0] dv[N];
    logic         n_rst   = 1'b0;
    logic         n_stray = 1'b0;
    bit           auto    = 1'b0;
    logic [N-1:0] last_ack;

    function automatic int pick();
        for (int k = 0; k < N; k++) begin
            if (rv[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return 0;
    endfunction

    task automatic new_op(input int i);
        int r;
        rv[i] = 1'b1;
        dd[i] = W'($urandom);
        r = $urandom_range(0, 7);
        if (r == 0)      dv[i] = '0;
        else if (r == 1) dv[i] = W'($urandom);
        else             dv[i] = W'($urandom_range(1, 300));
    endtask

    task automatic cycle();
        logic [N-1:0] e_ack, e_rsp;
        logic         e_en, e_busy;
        int           g;
        @(posedge clk);
        #1;
        rst       = n_rst;
        stray     = n_stray;
        req_valid = rv;
        for (int i = 0; i < N; i++) begin
            req_dividend[i*W +: W] = dd[i];
            req_divisor[i*W +: W]  = dv[i];
        end
        @(negedge clk);
        e_ack  = '0;
        e_rsp  = '0;
        e_en   = 1'b0;
        e_busy = m_busy;
        if (m_busy) begin
            m_t++;
            e_en = !m_zero && (m_t == 1);
            if (m_t == (m_zero ? 1 : 20)) begin
                e_rsp = N'(1) << m_g;
                if (exp_q.size() > 0) m_rspq = exp_q.pop_front();
                else check("scoreboard_empty", 32'd1, 32'd0);
            end
        end else if (rst && (rv != 0)) begin
            g      = pick();
            e_ack  = N'(1) << g;
            m_busy = 1'b1;
            m_t    = 0;
            m_g    = g;
            m_dd   = dd[g];
            m_dv   = dv[g];
            m_zero = BYPASS && (dv[g] == '0);
            if (m_zero) exp_q.push_back(dd[g][W-1] ? 16'h8000 : 16'h7FFF);
            else        exp_q.push_back(ref_div(dd[g], dv[g]));
        end
        check("req_ack", 32'(req_ack), 32'(e_ack));
        check("div_en", 32'(div_en), 32'(e_en));
        check("rsp_valid", 32'(rsp_valid), 32'(e_rsp));
        check("busy", 32'(busy), 32'(e_busy));
        check("rsp_quotient", 32'(rsp_quotient), 32'(m_rspq));
        if (e_en) begin
            check("div_dividend", 32'(div_dividend), 32'(m_dd));
            check("div_divisor", 32'(div_divisor), 32'(m_dv));
        end
        if (e_rsp != 0) begin
            m_busy = 1'b0;
            m_ptr  = (m_g + 1) % N;
        end
        if (!rst) begin
            m_busy = 1'b0;
            m_ptr  = 0;
            m_rspq = '0;
            exp_q.delete();
        end
        // Requesters: drop (or reissue) after ack, random arrivals and withdrawals.
        last_ack = req_ack;
        for (int i = 0; i < N; i++) begin
            if (last_ack[i]) begin
                if (auto && $urandom_range(0, 3) == 0) new_op(i);
                else rv[i] = 1'b0;
            end else if (auto) begin
                if (!rv[i] && $urandom_range(0, 15) == 0) new_op(i);
                else if (rv[i] && $urandom_range(0, 99) == 0) rv[i] = 1'b0;
            end
        end
        if (auto) begin
            n_stray = !m_busy && ($urandom_range(0, 9) == 0);
            n_rst   = ($urandom_range(0, 599) != 0);
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic req(input int i, input int a, input int b);
        rv[i] = 1'b1;
        dd[i] = W'(a);
        dv[i] = W'(b);
    endtask

    task automatic wait_ack(input int i);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 120 && !seen; k++) begin
            cycle();
            seen = last_ack[i];
        end
        if (!seen) check("ack_timeout", 32'd0, 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < N; i++) begin
            dd[i] = '0;
            dv[i] = '0;
        end
        rst          = 1'b0;
        stray        = 1'b0;
        req_valid    = '0;
        req_dividend = '0;
        req_divisor  = '0;
        run(3);
        n_rst = 1'b1;

        req(0, 100, 7);
        run(25);

        req(0, 1000, 10);
        req(1, -7, 2);
        req(2, -90, 9);
        req(3, 32767, 1);
        run(90);

        req(3, 77, 7);
        run(22);
        req(0, 12, 4);
        req(3, -64, 8);
        run(45);

        req(1, 500, 5);
        wait_ack(1);
        run(9);
        n_rst = 1'b0;
        req(1, 600, 6);
        run(1);
        n_rst = 1'b1;
        run(30);

        req(0, 50, 0);
        run(25);
        req(0, -50, 0);
        run(25);

        n_stray = 1'b1;
        run(1);
        n_stray = 1'b0;
        run(2);
        n_stray = 1'b1;
        run(1);
        n_stray = 1'b0;
        run(3);

        auto = 1'b1;
        run(3000);
        auto    = 1'b0;
        n_rst   = 1'b1;
        n_stray = 1'b0;
        rv      = '0;
        run(30);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
